// File: rtl/rx_header_parser_if.sv
// Signal bundle of the RX header parser: input stream, payload stream, header and statistics.
// slave is the parser side, master is the environment side.
interface rx_header_parser_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8
);
    localparam int unsigned MAC_W = 48;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned CNT_W = 32;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_axis_tkeep;
    logic                  s_axis_tvalid;
    logic                  s_axis_tuser;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tuser;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    logic                  hdr_valid;
    logic                  hdr_ready;
    logic [MAC_W-1:0]      hdr_dst_mac;
    logic [MAC_W-1:0]      hdr_src_mac;
    logic [LEN_W-1:0]      hdr_length;
    logic [NIB_W-1:0]      hdr_ihl;
    logic [NIB_W-1:0]      hdr_version;

    logic [CNT_W-1:0]      stat_frames_ok;
    logic [CNT_W-1:0]      stat_frames_bad;
    logic [CNT_W-1:0]      stat_frames_drop;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        input  m_axis_tready, hdr_ready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
        output hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_length, hdr_ihl, hdr_version,
        output stat_frames_ok, stat_frames_bad, stat_frames_drop
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        output m_axis_tready, hdr_ready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
        input  hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_length, hdr_ihl, hdr_version,
        input  stat_frames_ok, stat_frames_bad, stat_frames_drop
    );
endinterface

// File: rtl/rx_header_parser.sv
// Splits a 64-bit RX frame stream into a two-beat Ethernet/IPv4 header record and a
// forwarded payload stream, dropping runts and non-IPv4 frames, with frame statistics.
module rx_header_parser #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rx_axis_resetn,
    rx_header_parser_if.slave bus
);
    localparam int unsigned MAC_W = 48;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned CNT_W = 32;
    localparam logic [NIB_W-1:0] IPV4_VER = NIB_W'(4);

    typedef enum logic [1:0] {S_HDR0, S_HDR1, S_PAYLOAD, S_DROP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_s_ready;
    logic                  w_lat0;
    logic                  w_lat1;
    logic                  w_hdr_set;
    logic                  w_load;
    logic                  w_inc_ok;
    logic                  w_inc_bad;
    logic                  w_inc_drop;

    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic                  r_m_tuser;
    logic                  r_hdr_valid;
    logic [MAC_W-1:0]      r_dst_mac;
    logic [MAC_W-1:0]      r_src_mac;
    logic [LEN_W-1:0]      r_length;
    logic [NIB_W-1:0]      r_ihl;
    logic [NIB_W-1:0]      r_version;
    logic [CNT_W-1:0]      r_stat_ok;
    logic [CNT_W-1:0]      r_stat_bad;
    logic [CNT_W-1:0]      r_stat_drop;

    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) r_state <= S_HDR0;
        else                 r_state <= w_state_next;
    end

    // Next state, input ready and per-beat action strobes
    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_lat0       = 1'b0;
        w_lat1       = 1'b0;
        w_hdr_set    = 1'b0;
        w_load       = 1'b0;
        w_inc_ok     = 1'b0;
        w_inc_bad    = 1'b0;
        w_inc_drop   = 1'b0;
        case (r_state)
            S_HDR0: begin
                w_s_ready = !r_hdr_valid;
                if (bus.s_axis_tvalid && w_s_ready) begin
                    w_lat0 = 1'b1;
                    if (bus.s_axis_tlast) w_inc_drop   = 1'b1;
                    else                  w_state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                w_s_ready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    w_lat1 = 1'b1;
                    if (bus.s_axis_tlast) begin
                        w_inc_drop   = 1'b1;
                        w_state_next = S_HDR0;
                    end else if (bus.s_axis_tdata[51:48] != IPV4_VER) begin
                        w_inc_drop   = 1'b1;
                        w_state_next = S_DROP;
                    end else begin
                        w_hdr_set    = 1'b1;
                        w_state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                w_s_ready = !r_m_tvalid || bus.m_axis_tready;
                if (bus.s_axis_tvalid && w_s_ready) begin
                    w_load = 1'b1;
                    if (bus.s_axis_tlast) begin
                        w_inc_ok     = bus.s_axis_tuser;
                        w_inc_bad    = !bus.s_axis_tuser;
                        w_state_next = S_HDR0;
                    end
                end
            end
            S_DROP: begin
                w_s_ready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) w_state_next = S_HDR0;
            end
            default: w_state_next = S_HDR0;
        endcase
    end

    // Header record; fields only move while hdr_valid is low
    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) begin
            r_hdr_valid <= 1'b0;
            r_dst_mac   <= '0;
            r_src_mac   <= '0;
            r_length    <= '0;
            r_ihl       <= '0;
            r_version   <= '0;
        end else begin
            if (w_lat0) begin
                r_dst_mac        <= bus.s_axis_tdata[47:0];
                r_src_mac[15:0]  <= bus.s_axis_tdata[63:48];
            end
            if (w_lat1) begin
                r_src_mac[47:16] <= bus.s_axis_tdata[31:0];
                r_length         <= bus.s_axis_tdata[47:32];
                r_version        <= bus.s_axis_tdata[51:48];
                r_ihl            <= bus.s_axis_tdata[55:52];
            end
            if (w_hdr_set)                         r_hdr_valid <= 1'b1;
            else if (r_hdr_valid && bus.hdr_ready) r_hdr_valid <= 1'b0;
        end
    end

    // Single-entry payload output register
    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= bus.s_axis_tdata;
            r_m_tkeep  <= bus.s_axis_tkeep;
            r_m_tlast  <= bus.s_axis_tlast;
            r_m_tuser  <= bus.s_axis_tuser;
        end else if (bus.m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Frame statistics, free-running wrap
    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) begin
            r_stat_ok   <= '0;
            r_stat_bad  <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_inc_ok)   r_stat_ok   <= r_stat_ok   + CNT_W'(1);
            if (w_inc_bad)  r_stat_bad  <= r_stat_bad  + CNT_W'(1);
            if (w_inc_drop) r_stat_drop <= r_stat_drop + CNT_W'(1);
        end
    end

    // Ready is forced low while reset is held
    assign bus.s_axis_tready    = rx_axis_resetn & w_s_ready;
    assign bus.m_axis_tdata     = r_m_tdata;
    assign bus.m_axis_tkeep     = r_m_tkeep;
    assign bus.m_axis_tvalid    = r_m_tvalid;
    assign bus.m_axis_tlast     = r_m_tlast;
    assign bus.m_axis_tuser     = r_m_tuser;
    assign bus.hdr_valid        = r_hdr_valid;
    assign bus.hdr_dst_mac      = r_dst_mac;
    assign bus.hdr_src_mac      = r_src_mac;
    assign bus.hdr_length       = r_length;
    assign bus.hdr_ihl          = r_ihl;
    assign bus.hdr_version      = r_version;
    assign bus.stat_frames_ok   = r_stat_ok;
    assign bus.stat_frames_bad  = r_stat_bad;
    assign bus.stat_frames_drop = r_stat_drop;
endmodule

// File: tb/tb_rx_header_parser.sv
// Bench for rx_header_parser: directed frame table, backpressure and reset sequences,
// then random frames checked against a frame-level reference model.
module tb_rx_header_parser;
    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] len;
        logic [3:0]  ver;
        logic [3:0]  ihl;
    } hdr_t;

    typedef struct {
        logic [63:0] b1;
        int          n_total;
        bit          user;
        bit          exp_hdr;
        logic [15:0] exp_len;
        logic [3:0]  exp_ihl;
        int          exp_beats;
        int          exp_ok;
        int          exp_bad;
        int          exp_drop;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_header_parser_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

    rx_header_parser #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk            (clk),
        .rx_axis_resetn (rst_n),
        .bus            (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    n_mbeats = 0;
    int    m_ok     = 0;
    int    m_bad    = 0;
    int    m_drop   = 0;
    int    mt_mode  = 0;
    int    hr_mode  = 0;
    beat_t frame[$];
    beat_t exp_pay[$];
    hdr_t  exp_hdr[$];
    vec_t  tbl[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Downstream and header-consumer readiness: 0 always ready, 1 toggle/hold-off, 2 random
    always @(posedge clk) begin
        #1;
        case (mt_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = ~bus.m_axis_tready;
            default: bus.m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        case (hr_mode)
            0:       bus.hdr_ready = 1'b1;
            1:       bus.hdr_ready = 1'b0;
            default: bus.hdr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: every payload transfer and header handshake must match the next expectation
    always @(negedge clk) begin
        beat_t e;
        hdr_t  h;
        if (rst_n) begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                n_mbeats++;
                if (exp_pay.size() == 0) flag_fail("unexpected_payload_beat");
                else begin
                    e = exp_pay.pop_front();
                    chk("payload_beat",
                        128'({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
                              bus.m_axis_tlast & bus.m_axis_tuser}),
                        128'({e.d, e.k, e.l, e.l & e.u}));
                end
            end
            if (bus.hdr_valid && bus.hdr_ready) begin
                if (exp_hdr.size() == 0) flag_fail("unexpected_header");
                else begin
                    h = exp_hdr.pop_front();
                    chk("header",
                        128'({bus.hdr_dst_mac, bus.hdr_src_mac, bus.hdr_length,
                              bus.hdr_version, bus.hdr_ihl}),
                        128'({h.dst, h.src, h.len, h.ver, h.ihl}));
                end
            end
        end
    end

    task automatic build_frame(input logic [63:0] b0, input logic [63:0] b1, input int n_total,
                               input logic [63:0] pay_base, input bit user);
        beat_t b;
        frame.delete();
        for (int i = 0; i < n_total; i++) begin
            if (i == 0)      b.d = b0;
            else if (i == 1) b.d = b1;
            else             b.d = pay_base + 64'(8 * (i - 2));
            b.k = (i >= 2 && i == n_total - 1) ? 8'h3F : 8'hFF;
            b.l = (i == n_total - 1);
            b.u = (i == n_total - 1) ? user : 1'b0;
            frame.push_back(b);
        end
    endtask

    // Frame-level reference: <=2 beats is a runt, non-4 version is dropped, else header + payload
    task automatic model_frame();
        hdr_t h;
        int   n;
        n = frame.size();
        if (n <= 2) m_drop++;
        else if (frame[1].d[51:48] != 4'd4) m_drop++;
        else begin
            h.dst = frame[0].d[47:0];
            h.src = {frame[1].d[31:0], frame[0].d[63:48]};
            h.len = frame[1].d[47:32];
            h.ver = 4'd4;
            h.ihl = frame[1].d[55:52];
            exp_hdr.push_back(h);
            for (int i = 2; i < n; i++) exp_pay.push_back(frame[i]);
            if (frame[n-1].u) m_ok++;
            else              m_bad++;
        end
    endtask

    task automatic send_beat(input beat_t b);
        int n;
        bus.s_axis_tdata  = b.d;
        bus.s_axis_tkeep  = b.k;
        bus.s_axis_tlast  = b.l;
        bus.s_axis_tuser  = b.u;
        bus.s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_axis_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_axis_tready) flag_fail("s_axis_tready_timeout");
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame_from(input int first, input int max_gap);
        for (int i = first; i < frame.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_beat(frame[i]);
        end
    endtask

    task automatic wait_drain(input bit incl_hdr);
        int n;
        n = 0;
        while ((exp_pay.size() != 0 || (incl_hdr && exp_hdr.size() != 0)) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 128'(exp_pay.size() + (incl_hdr ? exp_hdr.size() : 0)), 128'd0);
    endtask

    task automatic chk_stats(input string name, input int ok, input int bad, input int drop);
        chk(name, 128'({bus.stat_frames_ok, bus.stat_frames_bad, bus.stat_frames_drop}),
            128'({32'(ok), 32'(bad), 32'(drop)}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int    base;
        int    stalled;
        hdr_t  h;
        beat_t b;

        //        b1                      n  usr hdr len     ihl beats ok bad drop
        tbl[0] = '{64'h0054_001E_0000_0000, 6, 1, 1, 16'h1E,  4'd5, 4, 1, 0, 0};
        tbl[1] = '{64'h0056_001E_0000_0000, 6, 1, 0, 16'h0,   4'd0, 0, 1, 0, 1};
        tbl[2] = '{64'h0054_001E_0000_0000, 6, 1, 1, 16'h1E,  4'd5, 4, 2, 0, 1};
        tbl[3] = '{64'h0054_001E_0000_0000, 2, 1, 0, 16'h0,   4'd0, 0, 2, 0, 2};
        tbl[4] = '{64'h0054_001E_0000_0000, 6, 0, 1, 16'h1E,  4'd5, 4, 2, 1, 2};
        tbl[5] = '{64'h0064_0100_0000_0000, 3, 1, 1, 16'h100, 4'd6, 1, 3, 1, 2};
        tbl[6] = '{64'h0054_001E_0000_0000, 1, 1, 0, 16'h0,   4'd0, 0, 3, 1, 3};
        tbl[7] = '{64'h0050_0040_0000_0000, 5, 1, 0, 16'h0,   4'd0, 0, 3, 1, 4};

        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.hdr_ready     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_low", 128'(bus.s_axis_tready), 128'd0);
        chk("reset_outputs", 128'({bus.m_axis_tvalid, bus.hdr_valid, bus.stat_frames_ok,
                                   bus.stat_frames_bad, bus.stat_frames_drop}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 128'(bus.s_axis_tready), 128'd1);

        for (int r = 0; r < 8; r++) begin
            build_frame(64'h0002_0000_0000_0001, tbl[r].b1, tbl[r].n_total, 64'h0, tbl[r].user);
            if (tbl[r].exp_hdr) begin
                h = '{48'h1, 48'h2, tbl[r].exp_len, 4'd4, tbl[r].exp_ihl};
                exp_hdr.push_back(h);
                for (int i = 2; i < frame.size(); i++) exp_pay.push_back(frame[i]);
            end
            base = n_mbeats;
            send_frame_from(0, 0);
            wait_drain(1);
            chk($sformatf("row%0d_beats", r), 128'(n_mbeats - base), 128'(tbl[r].exp_beats));
            chk($sformatf("row%0d_ok", r), 128'(bus.stat_frames_ok), 128'(tbl[r].exp_ok));
            chk($sformatf("row%0d_bad", r), 128'(bus.stat_frames_bad), 128'(tbl[r].exp_bad));
            chk($sformatf("row%0d_drop", r), 128'(bus.stat_frames_drop), 128'(tbl[r].exp_drop));
        end

        // Payload toggling backpressure with the header held; next beat0 must stall
        mt_mode = 1;
        hr_mode = 1;
        base = n_mbeats;
        build_frame(64'h0002_0000_0000_0001, 64'h0054_001E_0000_0000, 6, 64'h0, 1'b1);
        model_frame();
        send_frame_from(0, 0);
        wait_drain(0);
        build_frame(64'h0004_0000_0000_0007, 64'h0054_0022_0000_0000, 4, 64'h500, 1'b1);
        model_frame();
        bus.s_axis_tdata  = frame[0].d;
        bus.s_axis_tkeep  = frame[0].k;
        bus.s_axis_tlast  = frame[0].l;
        bus.s_axis_tuser  = frame[0].u;
        bus.s_axis_tvalid = 1'b1;
        stalled = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.s_axis_tready) stalled++;
        end
        chk("bp_beat0_stalled", 128'(stalled), 128'd0);
        chk("bp_hdr_valid_held", 128'(bus.hdr_valid), 128'd1);
        hr_mode = 0;
        send_frame_from(0, 0);
        mt_mode = 0;
        wait_drain(1);
        chk("bp_beats", 128'(n_mbeats - base), 128'd6);
        chk_stats("bp_stats", 5, 1, 4);

        // Asynchronous reset while the second payload beat is presented
        build_frame(64'h0002_0000_0000_0001, 64'h0054_001E_0000_0000, 6, 64'h1111_0000_0000_0100, 1'b1);
        model_frame();
        for (int i = 0; i < 3; i++) send_beat(frame[i]);
        bus.s_axis_tdata  = frame[3].d;
        bus.s_axis_tkeep  = frame[3].k;
        bus.s_axis_tlast  = frame[3].l;
        bus.s_axis_tvalid = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs_zero",
            128'(|{bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser,
                   bus.m_axis_tdata, bus.m_axis_tkeep, bus.hdr_valid, bus.hdr_dst_mac,
                   bus.hdr_src_mac, bus.hdr_length, bus.hdr_ihl, bus.hdr_version,
                   bus.stat_frames_ok, bus.stat_frames_bad, bus.stat_frames_drop}), 128'd0);
        bus.s_axis_tvalid = 1'b0;
        exp_pay.delete();
        exp_hdr.delete();
        m_ok   = 0;
        m_bad  = 0;
        m_drop = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        build_frame(64'hDEAD_BEEF_CAFE_1234, 64'h0054_0010_1111_2222, 3, 64'h77, 1'b1);
        model_frame();
        send_beat(frame[0]);
        chk("post_reset_dst_mac", 128'(bus.hdr_dst_mac), 128'h0000_BEEF_CAFE_1234);
        send_frame_from(1, 0);
        wait_drain(1);
        chk_stats("post_reset_stats", 1, 0, 0);

        // Random frames against the frame-level model
        mt_mode = 2;
        hr_mode = 2;
        for (int f = 0; f < 40; f++) begin
            b.d = {$urandom, $urandom};
            build_frame({$urandom, $urandom}, b.d, int'($urandom_range(1, 6)),
                        {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            if (frame.size() > 1 && $urandom_range(0, 4) != 0) frame[1].d[51:48] = 4'd4;
            for (int i = 0; i < frame.size(); i++) frame[i].k = 8'($urandom);
            model_frame();
            send_frame_from(0, 2);
        end
        wait_drain(1);
        chk_stats("random_stats", m_ok, m_bad, m_drop);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_header_parser.md
RX_HEADER_PARSER -- requirements
Module: rx_header_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 64, stream data width; only 64 is supported.
REQ-002 Parameter KEEP_WIDTH, default 8, tkeep width; only 8 is supported.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock; all logic is rising-edge.
- rx_axis_resetn, in, 1: asynchronous, active-low reset.
- s_axis_tdata, in, 64: frame beats from the MAC RX master.
- s_axis_tkeep, in, 8: byte enables for s_axis_tdata.
- s_axis_tvalid, in, 1: upstream beat valid.
- s_axis_tuser, in, 1: on the tlast beat, 1 means good frame.
- s_axis_tlast, in, 1: last beat of the frame.
- s_axis_tready, out, 1: parser can accept a beat.
- m_axis_tdata, out, 64: payload beats.
- m_axis_tkeep, out, 8: payload byte enables.
- m_axis_tvalid, out, 1: payload beat valid.
- m_axis_tuser, out, 1: good-frame flag, meaningful only with m_axis_tlast.
- m_axis_tlast, out, 1: last payload beat.
- m_axis_tready, in, 1: downstream accepts the payload beat.
- hdr_valid, out, 1: parsed header available.
- hdr_ready, in, 1: header consumer accepts the header.
- hdr_dst_mac, out, 48: destination MAC address.
- hdr_src_mac, out, 48: source MAC address.
- hdr_length, out, 16: length field.
- hdr_ihl, out, 4: IHL field.
- hdr_version, out, 4: version field.
- stat_frames_ok, out, 32: count of good frames.
- stat_frames_bad, out, 32: count of bad frames.
- stat_frames_drop, out, 32: count of dropped frames.

Function
REQ-004 A beat is accepted when s_axis_tvalid and s_axis_tready are both 1; an output beat transfers when m_axis_tvalid and m_axis_tready are both 1.
REQ-005 The parser SHALL implement four states: HDR0, HDR1, PAYLOAD, DROP.
REQ-006 HDR0 SHALL work as follows:
- s_axis_tready = !hdr_valid.
- On an accepted beat, latch hdr_dst_mac <= tdata[47:0] and hdr_src_mac[15:0] <= tdata[63:48], then go to HDR1.
REQ-007 HDR1 SHALL work as follows:
- s_axis_tready = 1.
- On an accepted beat, latch hdr_src_mac[47:16] <= tdata[31:0], hdr_length <= tdata[47:32], hdr_version <= tdata[51:48] and hdr_ihl <= tdata[55:52].
REQ-008 HDR1 exits SHALL be taken in this priority order:
- tlast = 1 (runt frame): increment stat_frames_drop, leave hdr_valid at 0, go to HDR0.
- Otherwise, tdata[51:48] != 4: increment stat_frames_drop, go to DROP.
- Otherwise: set hdr_valid = 1, go to PAYLOAD.
REQ-009 A tlast on an HDR0 beat SHALL increment stat_frames_drop and keep the state at HDR0.
REQ-010 hdr_valid SHALL remain 1, with all hdr_* fields stable, until the cycle after hdr_valid and hdr_ready are both 1; it then clears.
REQ-011 PAYLOAD SHALL work as follows:
- s_axis_tready = !m_axis_tvalid || m_axis_tready.
- Each accepted beat is registered into the output stage, so tdata, tkeep, tlast and tuser appear on m_axis one cycle later, unmodified.
REQ-012 The output stage SHALL be a single register: m_axis_tvalid clears after a transfer unless a new beat is loaded in the same cycle. Full throughput is one beat per cycle.
REQ-013 On the accepted tlast beat in PAYLOAD, the parser SHALL go to HDR0 and increment stat_frames_ok if tuser = 1, otherwise stat_frames_bad.
REQ-014 DROP SHALL hold s_axis_tready = 1, discard beats without forwarding them, and go to HDR0 on the accepted tlast beat.
REQ-015 m_axis outputs SHALL never assert during HDR0, HDR1 or DROP, except to complete a beat already held in the output register.
REQ-016 Statistics counters SHALL increment by exactly 1 per event and wrap from 2^32-1 to 0.
REQ-017 The header handshake and the next frame's HDR0 beat SHALL NOT overlap: HDR0 accepts nothing while hdr_valid = 1.
REQ-018 tkeep on header beats SHALL be ignored.

Reset
REQ-019 While rx_axis_resetn = 0, the following SHALL be forced immediately, independent of clk:
- state = HDR0.
- m_axis_tvalid, m_axis_tlast, m_axis_tuser and hdr_valid = 0.
- m_axis_tdata, m_axis_tkeep and all hdr_* fields = 0.
- All stat_* counters = 0.
- s_axis_tready = 0.
REQ-020 After reset deasserts, s_axis_tready SHALL return to 1 (HDR0 with hdr_valid = 0). The first accepted beat is parsed as HDR0; there is no frame resynchronisation, so a reset mid-frame parses the remainder of that frame as a new frame.

Verification
REQ-021 Good frame:
- Stimulus: beat0 = 0x0002_0000_0000_0001; beat1 = 0x0054_001E_0000_0000; payload 0x0, 0x8, 0x10 with tkeep FF; last beat 0x18 with tkeep 3F, tuser = 1.
- Response: hdr_dst_mac = 1, hdr_src_mac = 2, hdr_length = 0x1E, hdr_ihl = 5, hdr_version = 4; four m_axis beats with identical data/tkeep; stat_frames_ok = 1.
REQ-022 Backpressure:
- Stimulus: same frame with m_axis_tready toggling 1/0 every cycle and hdr_ready held 0.
- Response: no beat lost or duplicated; the next frame's beat0 is stalled (s_axis_tready = 0) until hdr_ready pulses.
REQ-023 Version mismatch:
- Stimulus: beat1 = 0x0056_001E_0000_0000.
- Response: no hdr_valid; no m_axis beats; stat_frames_drop = 1; next frame parses normally.
REQ-024 Runt:
- Stimulus: tlast on beat1.
- Response: stat_frames_drop = 1; state returns to HDR0; no hdr_valid.
REQ-025 Bad frame:
- Stimulus: good frame with tuser = 0 on tlast.
- Response: payload forwarded with m_axis_tuser = 0 on the last beat; stat_frames_bad = 1.
REQ-026 Reset mid-frame:
- Stimulus: assert rx_axis_resetn = 0 during the second payload beat.
- Response: all outputs are 0 within the same cycle, before the next clk edge; after release, the next accepted beat is latched as hdr_dst_mac.
